// File: rtl/vram_arbiter.sv
// VRAM arbiter: one byte-wide CPU port and NUM_RD word-wide read channels sharing
// one single-port synchronous RAM, with starvation-driven pre-emption of the CPU.
module vram_arbiter #(
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RR_EN    = 1,
    parameter int unsigned MAX_WAIT = 7,
    localparam int unsigned BYTES   = DATA_W / 8,
    localparam int unsigned BSEL_W  = $clog2(BYTES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W+BSEL_W-1:0]   cpu_addr,
    input  logic [7:0]                 cpu_wrdata,
    input  logic                       cpu_write,
    input  logic                       cpu_strobe,
    output logic                       cpu_ack,
    output logic [7:0]                 cpu_rddata,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD-1:0]          rd_strobe,
    output logic [NUM_RD-1:0]          rd_ack,
    output logic [DATA_W-1:0]          rd_rddata,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_wrdata,
    output logic [BYTES-1:0]           ram_wrbytesel,
    output logic                       ram_write,
    input  logic [DATA_W-1:0]          ram_rddata
);
    localparam int unsigned LANE_W = (BSEL_W > 0) ? BSEL_W : 1;
    localparam int unsigned PTR_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [LANE_W-1:0] w_lane;
    logic [ADDR_W-1:0] w_cpu_word;
    logic [ADDR_W-1:0] w_rd_word;
    logic              w_gnt_cpu;
    logic              w_gnt_any_rd;
    logic [NUM_RD-1:0] w_gnt_rd;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic [7:0]        w_cpu_byte;
    logic [BYTES-1:0]  w_bsel;

    logic              r_cpu_ack;
    logic [NUM_RD-1:0] r_rd_ack;
    logic [7:0]        r_hold;
    logic [LANE_W-1:0] r_lane;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [WAIT_W-1:0] r_wait [NUM_RD];

    generate
        if (BSEL_W > 0) begin : g_lane
            assign w_lane     = cpu_addr[BSEL_W-1:0];
            assign w_cpu_word = cpu_addr[ADDR_W+BSEL_W-1:BSEL_W];
        end else begin : g_nolane
            assign w_lane     = '0;
            assign w_cpu_word = cpu_addr;
        end
    endgenerate

    // Urgent readers first, then CPU, then the normal read search.
    always_comb begin
        int unsigned c;
        c            = 0;
        w_gnt_cpu    = 1'b0;
        w_gnt_any_rd = 1'b0;
        w_gnt_rd     = '0;
        w_gnt_idx    = '0;
        if (MAX_WAIT > 0) begin
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                if (!w_gnt_any_rd && rd_strobe[i] && (r_wait[i] == WAIT_MAX)) begin
                    w_gnt_any_rd = 1'b1;
                    w_gnt_rd[i]  = 1'b1;
                    w_gnt_idx    = PTR_W'(i);
                end
            end
        end
        if (!w_gnt_any_rd) begin
            if (cpu_strobe) begin
                w_gnt_cpu = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NUM_RD; k++) begin
                    c = (RR_EN != 0) ? ((32'(r_rr_ptr) + 1 + k) % NUM_RD) : k;
                    if (!w_gnt_any_rd && rd_strobe[c]) begin
                        w_gnt_any_rd = 1'b1;
                        w_gnt_rd[c]  = 1'b1;
                        w_gnt_idx    = PTR_W'(c);
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (w_gnt_rd[i]) w_rd_word = rd_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        w_bsel         = '0;
        w_bsel[w_lane] = 1'b1;
    end

    assign w_cpu_byte    = ram_rddata[32'(r_lane)*8 +: 8];
    assign ram_addr      = w_gnt_cpu ? w_cpu_word : w_rd_word;
    assign ram_wrdata    = {BYTES{cpu_wrdata}};
    assign ram_wrbytesel = w_bsel;
    assign ram_write     = rst_n & w_gnt_cpu & cpu_write;
    assign rd_rddata     = ram_rddata;
    assign cpu_ack       = r_cpu_ack;
    assign rd_ack        = r_rd_ack;
    assign cpu_rddata    = r_cpu_ack ? w_cpu_byte : r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_ack <= 1'b0;
            r_rd_ack  <= '0;
            r_hold    <= '0;
            r_lane    <= '0;
            r_rr_ptr  <= PTR_W'(NUM_RD - 1);
        end else begin
            r_cpu_ack <= w_gnt_cpu;
            r_rd_ack  <= w_gnt_rd;
            if (w_gnt_cpu)    r_lane   <= w_lane;
            if (w_gnt_any_rd) r_rr_ptr <= w_gnt_idx;
            if (r_cpu_ack)    r_hold   <= w_cpu_byte;
        end
    end

    // Wait counters saturate at MAX_WAIT; with MAX_WAIT=0 they stay at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_RD; i++) r_wait[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                if (!rd_strobe[i] || w_gnt_rd[i]) r_wait[i] <= '0;
                else if (r_wait[i] != WAIT_MAX)   r_wait[i] <= r_wait[i] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: instance a (round-robin, MAX_WAIT=7) and instance b
// (fixed priority, MAX_WAIT=0) share stimulus, each with its own RAM model.
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wrdata;
    logic        cpu_write;
    logic        cpu_strobe;
    logic [44:0] rd_addr;
    logic [2:0]  rd_strobe;

    logic        cpu_ack_a, cpu_ack_b;
    logic [7:0]  cpu_rddata_a, cpu_rddata_b;
    logic [2:0]  rd_ack_a, rd_ack_b;
    logic [31:0] rd_rddata_a, rd_rddata_b;
    logic [14:0] ram_addr_a, ram_addr_b;
    logic [31:0] ram_wrdata_a, ram_wrdata_b;
    logic [3:0]  ram_wrbytesel_a, ram_wrbytesel_b;
    logic        ram_write_a, ram_write_b;
    logic [31:0] ram_rddata_a, ram_rddata_b;

    // Memories hold the delta from a per-address base pattern, so they start at zero.
    logic [31:0] mem_a [256] = '{default: '0};
    logic [31:0] mem_b [256] = '{default: '0};

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.NUM_RD(3), .ADDR_W(15), .DATA_W(32), .RR_EN(1), .MAX_WAIT(7)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
        .cpu_write(cpu_write), .cpu_strobe(cpu_strobe), .cpu_ack(cpu_ack_a),
        .cpu_rddata(cpu_rddata_a), .rd_addr(rd_addr), .rd_strobe(rd_strobe),
        .rd_ack(rd_ack_a), .rd_rddata(rd_rddata_a), .ram_addr(ram_addr_a),
        .ram_wrdata(ram_wrdata_a), .ram_wrbytesel(ram_wrbytesel_a),
        .ram_write(ram_write_a), .ram_rddata(ram_rddata_a));

    vram_arbiter #(.NUM_RD(3), .ADDR_W(15), .DATA_W(32), .RR_EN(0), .MAX_WAIT(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
        .cpu_write(cpu_write), .cpu_strobe(cpu_strobe), .cpu_ack(cpu_ack_b),
        .cpu_rddata(cpu_rddata_b), .rd_addr(rd_addr), .rd_strobe(rd_strobe),
        .rd_ack(rd_ack_b), .rd_rddata(rd_rddata_b), .ram_addr(ram_addr_b),
        .ram_wrdata(ram_wrdata_b), .ram_wrbytesel(ram_wrbytesel_b),
        .ram_write(ram_write_b), .ram_rddata(ram_rddata_b));

    function automatic logic [31:0] pat(input logic [7:0] a);
        return 32'hC0DE_0000 | {24'h0, a};
    endfunction

    always @(posedge clk) begin
        logic [31:0] w;
        w = mem_a[ram_addr_a[7:0]] ^ pat(ram_addr_a[7:0]);
        ram_rddata_a <= w;
        if (ram_write_a) begin
            for (int b = 0; b < 4; b++)
                if (ram_wrbytesel_a[b]) w[b*8 +: 8] = ram_wrdata_a[b*8 +: 8];
            mem_a[ram_addr_a[7:0]] <= w ^ pat(ram_addr_a[7:0]);
        end
    end

    always @(posedge clk) begin
        logic [31:0] w;
        w = mem_b[ram_addr_b[7:0]] ^ pat(ram_addr_b[7:0]);
        ram_rddata_b <= w;
        if (ram_write_b) begin
            for (int b = 0; b < 4; b++)
                if (ram_wrbytesel_b[b]) w[b*8 +: 8] = ram_wrdata_b[b*8 +: 8];
            mem_b[ram_addr_b[7:0]] <= w ^ pat(ram_addr_b[7:0]);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        cpu_addr   = '0;
        cpu_wrdata = '0;
        cpu_write  = 1'b0;
        cpu_strobe = 1'b0;
        rd_addr    = {15'h30, 15'h20, 15'h10};
        rd_strobe  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // Reset state and idle bus
        check("rst_cpu_ack", cpu_ack_a, 0);
        check("rst_rd_ack", rd_ack_a, 0);
        check("rst_hold", cpu_rddata_a, 0);
        check("idle_ram_write", ram_write_a, 0);
        check("idle_ram_addr", ram_addr_a, 0);

        // CPU write 0xA5 to byte 6, then read it back
        cpu_addr = 17'h6; cpu_wrdata = 8'hA5; cpu_write = 1'b1; cpu_strobe = 1'b1;
        #1;
        check("wr_ram_addr", ram_addr_a, 15'h1);
        check("wr_bytesel", ram_wrbytesel_a, 4'b0100);
        check("wr_ram_write", ram_write_a, 1);
        check("wr_wrdata", ram_wrdata_a, 32'hA5A5_A5A5);
        tick();
        check("wr_cpu_ack", cpu_ack_a, 1);
        check("wr_old_byte", cpu_rddata_a, 8'hDE);
        check("wr_rd_ack", rd_ack_a, 0);
        cpu_write = 1'b0;
        #1;
        check("rdb_ram_write", ram_write_a, 0);
        tick();
        check("rdb_cpu_ack", cpu_ack_a, 1);
        check("rdb_data_a", cpu_rddata_a, 8'hA5);
        check("rdb_data_b", cpu_rddata_b, 8'hA5);
        cpu_strobe = 1'b0;
        tick();
        check("hold_ack", cpu_ack_a, 0);
        check("hold_data1", cpu_rddata_a, 8'hA5);
        tick();
        check("hold_data2", cpu_rddata_a, 8'hA5);

        // All readers request, CPU idle: round-robin vs fixed priority
        do_reset();
        rd_strobe = 3'b111;
        #1;
        check("rr_first_addr", ram_addr_a, 15'h10);
        check("fp_first_addr", ram_addr_b, 15'h10);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_ack", rd_ack_a, 3'b001 << (k % 3));
            check("rr_data", rd_rddata_a, pat(8'h10 + 8'((k % 3) * 16)));
            check("fp_ack", rd_ack_b, 3'b001);
            check("fp_data", rd_rddata_b, pat(8'h10));
        end
        check("rr_cpu_ack", cpu_ack_a, 0);

        // CPU every cycle with ch2 waiting: ch2 pre-empts every 8th cycle on a
        check_starve: begin
            do_reset();
            cpu_addr = 17'h6; cpu_strobe = 1'b1; rd_strobe = 3'b100;
            for (int k = 1; k <= 16; k++) begin
                if (k == 8) begin
                    #1;
                    check("urg_ram_addr", ram_addr_a, 15'h30);
                end
                tick();
                check("urg_cpu_ack", cpu_ack_a, (k % 8) != 0);
                check("urg_rd_ack", rd_ack_a, ((k % 8) == 0) ? 3'b100 : 3'b000);
                check("nowait_cpu_ack", cpu_ack_b, 1);
                check("nowait_rd_ack", rd_ack_b, 0);
            end
        end

        // CPU and ch0 together: b (MAX_WAIT=0) never serves ch0
        do_reset();
        cpu_addr = 17'h6; cpu_strobe = 1'b1; rd_strobe = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("mw0_cpu_ack", cpu_ack_b, 1);
            check("mw0_rd_ack", rd_ack_b, 0);
            check("mw7_rd_ack", rd_ack_a, (k == 8) ? 3'b001 : 3'b000);
        end

        // Reset asserted while a grant is pending
        do_reset();
        rd_strobe = 3'b111; cpu_addr = 17'h6; cpu_wrdata = 8'h5A;
        cpu_write = 1'b1; cpu_strobe = 1'b1;
        #1;
        check("pre_rst_write", ram_write_a, 1);
        rst_n = 1'b0;
        #1;
        check("in_rst_write_a", ram_write_a, 0);
        check("in_rst_write_b", ram_write_b, 0);
        tick();
        check("in_rst_cpu_ack", cpu_ack_a, 0);
        check("in_rst_rd_ack", rd_ack_a, 0);
        check("in_rst_hold", cpu_rddata_a, 0);
        cpu_strobe = 1'b0; cpu_write = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rst_addr", ram_addr_a, 15'h10);
        tick();
        check("post_rst_ack_a", rd_ack_a, 3'b001);
        check("post_rst_ack_b", rd_ack_b, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
